// File: rtl/spi_master_multi.sv
// SPI master with runtime CPOL/CPHA, programmable SCK divider, one-hot active-low chip
// selects and multi-word bursts; chip select stays asserted for the whole burst.
module spi_master_multi #(
    parameter int DATA_W    = 8,
    parameter int NUM_SS    = 8,
    parameter int SS_W      = 3,
    parameter int CLK_DIV   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              start,
    input  logic [SS_W-1:0]   ss,
    input  logic [1:0]        mode,
    input  logic [15:0]       len,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] cs_n
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGES  = 2 * DATA_W;
    localparam int EDGE_W = $clog2(EDGES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    state_t state;

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [EDGE_W-1:0] edge_nxt;
    logic [15:0]       word_cnt;
    logic [15:0]       len_q;
    logic [1:0]        mode_q;
    logic              last_word;
    logic              rx_pend;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              accept;
    logic              half_end;
    logic              sample_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    always_comb begin
        accept      = start && (len != 16'd0) && (int'(ss) < NUM_SS);
        half_end    = (div_cnt == DIV_W'(CLK_DIV - 1));
        edge_nxt    = (edge_cnt == EDGE_W'(EDGES)) ? EDGE_W'(1) : edge_cnt + EDGE_W'(1);
        // odd edges are leading; CPHA=0 samples on leading, CPHA=1 on trailing
        sample_edge = (edge_nxt[0] != mode_q[0]);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state     <= IDLE;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= '1;
            busy      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            done      <= 1'b0;
            tx_load   <= 1'b0;
            mode_q    <= '0;
            len_q     <= '0;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            word_cnt  <= '0;
            last_word <= 1'b0;
            rx_pend   <= 1'b0;
            tx_sh     <= '0;
            rx_sh     <= '0;
        end else begin
            tx_load  <= 1'b0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            if (rx_pend) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
                rx_pend  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SETUP;
                        busy      <= 1'b1;
                        mode_q    <= mode;
                        len_q     <= len;
                        cs_n      <= ~(NUM_SS'(1) << ss);
                        sck       <= mode[1];
                        tx_load   <= 1'b1;
                        div_cnt   <= '0;
                        edge_cnt  <= '0;
                        word_cnt  <= '0;
                        last_word <= 1'b0;
                        if (mode[0]) begin
                            tx_sh <= tx_data;
                            mosi  <= 1'b0;
                        end else begin
                            tx_sh <= shift_out(tx_data);
                            mosi  <= first_bit(tx_data);
                        end
                    end
                end
                SETUP, XFER: begin
                    div_cnt <= half_end ? '0 : div_cnt + DIV_W'(1);
                    if (half_end) begin
                        if (last_word) begin
                            state <= HOLD;
                        end else begin
                            state    <= XFER;
                            sck      <= ~sck;
                            edge_cnt <= edge_nxt;
                            if (sample_edge) begin
                                rx_sh <= shift_in(rx_sh, miso);
                            end else begin
                                mosi  <= first_bit(tx_sh);
                                tx_sh <= shift_out(tx_sh);
                            end
                            // word boundary: next word overrides the generic drive above
                            if (edge_nxt == EDGE_W'(EDGES)) begin
                                rx_pend  <= 1'b1;
                                word_cnt <= word_cnt + 16'd1;
                                if (word_cnt == len_q - 16'd1) begin
                                    last_word <= 1'b1;
                                end else begin
                                    tx_load <= 1'b1;
                                    if (mode_q[0]) begin
                                        tx_sh <= tx_data;
                                    end else begin
                                        mosi  <= first_bit(tx_data);
                                        tx_sh <= shift_out(tx_data);
                                    end
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    div_cnt <= half_end ? '0 : div_cnt + DIV_W'(1);
                    sck     <= mode_q[1];
                    if (half_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cs_n  <= '1;
                        mosi  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: two instances (MSB-first/div 2/6 selects and LSB-first/div 1/8 selects)
// driven one at a time against a behavioural SPI slave and timing model.
module tb_spi_master_multi;
    localparam int DW = 8;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic [2:0] ss     = '0;
    logic [1:0] mode   = '0;
    logic [15:0] len   = '0;
    logic [DW-1:0] tx_data = '0;
    logic       miso   = 1'b0;
    logic       sel    = 1'b0;

    logic start0, start1;
    logic tx_load0, rx_valid0, busy0, done0, sck0, mosi0;
    logic tx_load1, rx_valid1, busy1, done1, sck1, mosi1;
    logic [DW-1:0] rx_data0, rx_data1;
    logic [5:0] cs_n0;
    logic [7:0] cs_n1;

    logic m_tx_load, m_rx_valid, m_busy, m_done, m_sck, m_mosi;
    logic [DW-1:0] m_rx_data;
    logic [7:0] m_cs;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] g_tx[$];
    logic [DW-1:0] g_sl[$];

    always #5 sysclk = ~sysclk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign m_tx_load  = sel ? tx_load1  : tx_load0;
    assign m_rx_valid = sel ? rx_valid1 : rx_valid0;
    assign m_rx_data  = sel ? rx_data1  : rx_data0;
    assign m_busy     = sel ? busy1     : busy0;
    assign m_done     = sel ? done1     : done0;
    assign m_sck      = sel ? sck1      : sck0;
    assign m_mosi     = sel ? mosi1     : mosi0;
    assign m_cs       = sel ? cs_n1     : {2'b11, cs_n0};

    spi_master_multi #(.DATA_W(DW), .NUM_SS(6), .SS_W(3), .CLK_DIV(2), .MSB_FIRST(1)) u0 (
        .sysclk(sysclk), .rst(rst), .start(start0), .ss(ss), .mode(mode), .len(len),
        .tx_data(tx_data), .tx_load(tx_load0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .busy(busy0), .done(done0), .sck(sck0), .mosi(mosi0), .miso(miso), .cs_n(cs_n0)
    );

    spi_master_multi #(.DATA_W(DW), .NUM_SS(8), .SS_W(3), .CLK_DIV(1), .MSB_FIRST(0)) u1 (
        .sysclk(sysclk), .rst(rst), .start(start1), .ss(ss), .mode(mode), .len(len),
        .tx_data(tx_data), .tx_load(tx_load1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .busy(busy1), .done(done1), .sck(sck1), .mosi(mosi1), .miso(miso), .cs_n(cs_n1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic load_words(input int n, input bit loopback);
        g_tx.delete();
        g_sl.delete();
        for (int k = 0; k < n; k++) begin
            g_tx.push_back(DW'($urandom));
            g_sl.push_back(loopback ? g_tx[k] : DW'($urandom));
        end
    endtask

    // One burst on instance s; the slave answers with g_sl, upstream supplies g_tx on tx_load.
    task automatic run_txn(input logic s, input logic [1:0] md, input int n, input int ssi,
                           input int rst_at, input bit mid, input bit b2b);
        int cd, bound, edges, first_edge, last_edge, wend, gap_bad, dir_bad, cs_bad;
        int busy_cnt, tl_cnt, tl_bad, rv_cnt, rv_bad, done_cnt, sp, w, cnt, extra;
        bit msb, edge_now, lead;
        logic prev_sck;
        logic [7:0] cs_exp;
        logic [DW-1:0] word;
        bit sbits[$];
        bit mbits[$];

        cd  = s ? 1 : 2;
        msb = !s;
        cs_exp = ~(8'd1 << ssi);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < DW; i++)
                sbits.push_back(msb ? g_sl[k][DW-1-i] : g_sl[k][i]);

        @(negedge sysclk);
        sel = s; tx_data = g_tx[0]; mode = md; len = 16'(n); ss = 3'(ssi); start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;

        bound = cd * (2 * DW * n + 2) + 40;
        edges = 0; first_edge = -1; last_edge = 0; wend = -100; gap_bad = 0; dir_bad = 0;
        cs_bad = 0; busy_cnt = 0; tl_cnt = 0; tl_bad = 0; rv_cnt = 0; rv_bad = 0;
        done_cnt = 0; sp = 0; w = 0;
        prev_sck = md[1];
        for (int cyc = 0; cyc < bound; cyc++) begin
            if (cyc > 0) @(negedge sysclk);
            edge_now = 1'b0;
            if (cyc == 0 && md[0] == 1'b0) begin
                miso = sbits[0];
                sp = 1;
            end
            if (m_busy) busy_cnt++;
            if (m_busy && m_cs !== cs_exp) cs_bad++;
            if (m_sck !== prev_sck) begin
                edge_now = 1'b1;
                edges++;
                w = ((edges - 1) % (2 * DW)) + 1;
                lead = (w % 2) == 1;
                if (lead && m_sck === md[1]) dir_bad++;
                if (edges == 1) first_edge = cyc;
                else if (cyc - last_edge != cd) gap_bad++;
                last_edge = cyc;
                if (lead != md[0]) begin
                    mbits.push_back(m_mosi);
                end else begin
                    miso = (sp < sbits.size()) ? sbits[sp] : 1'b0;
                    sp++;
                end
                if (w == 2 * DW) wend = cyc;
                prev_sck = m_sck;
            end
            if (m_tx_load) begin
                if (tl_cnt == 0 && cyc != 0) tl_bad++;
                if (tl_cnt > 0 && !(edge_now && w == 2 * DW)) tl_bad++;
                tl_cnt++;
                tx_data = (tl_cnt < n) ? g_tx[tl_cnt] : DW'($urandom);
            end
            if (m_rx_valid) begin
                if (rv_cnt < n) check("rx_word", m_rx_data, g_sl[rv_cnt]);
                if (cyc != wend + 1) rv_bad++;
                rv_cnt++;
            end
            if (mid && cyc == 5 * cd) begin
                start = 1'b1; ss = 3'd0; mode = ~md; len = 16'd7;
            end
            if (mid && cyc == 5 * cd + 1) start = 1'b0;
            if (m_done) begin
                done_cnt++;
                check("done_cs", m_cs, 8'hFF);
                check("done_busy", m_busy, 0);
                check("done_sck", m_sck, md[1]);
                check("done_mosi", m_mosi, 0);
                break;
            end
            if (rst_at != 0 && edge_now && edges == rst_at) begin
                rst = 1'b1;
                @(negedge sysclk);
                check("rst_cs", m_cs, 8'hFF);
                check("rst_sck", m_sck, 0);
                check("rst_busy", m_busy, 0);
                rst = 1'b0;
                miso = 1'b0;
                extra = 0;
                for (int i = 0; i < 4 * DW * cd; i++) begin
                    @(negedge sysclk);
                    if (m_rx_valid || m_done || m_busy) extra++;
                end
                check("rst_quiet", extra, 0);
                return;
            end
        end
        miso = 1'b0;

        check("busy_len", busy_cnt, cd * (2 * DW * n + 2));
        check("edges", edges, 2 * DW * n);
        check("first_edge", first_edge, cd);
        check("edge_gap", gap_bad, 0);
        check("edge_dir", dir_bad, 0);
        check("cs_hold", cs_bad, 0);
        check("tx_load_cnt", tl_cnt, n);
        check("tx_load_time", tl_bad, 0);
        check("rx_valid_cnt", rv_cnt, n);
        check("rx_valid_time", rv_bad, 0);
        check("done_cnt", done_cnt, 1);
        check("mosi_bits", mbits.size(), DW * n);
        for (int k = 0; k < n; k++) begin
            word = '0;
            for (int i = 0; i < DW; i++) begin
                if (msb) word = {word[DW-2:0], (DW * k + i < mbits.size()) ? mbits[DW * k + i] : 1'b0};
                else word[i] = (DW * k + i < mbits.size()) ? mbits[DW * k + i] : 1'b0;
            end
            check("mosi_word", word, g_tx[k]);
        end

        if (b2b) begin
            // still in the done cycle: this start must be accepted
            tx_data = DW'($urandom); len = 16'd1; ss = 3'(ssi); mode = md; start = 1'b1;
            @(negedge sysclk);
            start = 1'b0;
            check("b2b_busy", m_busy, 1);
            cnt = 1;
            for (int i = 0; i < 100; i++) begin
                @(negedge sysclk);
                if (m_done) break;
                if (m_busy) cnt++;
            end
            check("b2b_len", cnt, cd * (2 * DW + 2));
        end else begin
            extra = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge sysclk);
                if (m_busy || m_tx_load) extra++;
            end
            check("post_idle", extra, 0);
        end
    endtask

    task automatic try_ignored(input logic s, input int ssi, input int n);
        int bad;
        @(negedge sysclk);
        sel = s; ss = 3'(ssi); len = 16'(n); mode = 2'd0; tx_data = DW'($urandom); start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_busy || m_tx_load || m_done || m_cs !== 8'hFF) bad++;
            @(negedge sysclk);
        end
        check("ignored_start", bad, 0);
    endtask

    initial begin
        logic s;
        logic [1:0] md;
        int n, ssi;

        repeat (3) @(negedge sysclk);
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #1;
            check("reset_sck", m_sck, 0);
            check("reset_cs", m_cs, 8'hFF);
            check("reset_busy", m_busy, 0);
            check("reset_outs", {m_mosi, m_done, m_rx_valid, m_tx_load, m_rx_data}, 0);
        end
        rst = 1'b0;

        g_tx.delete(); g_sl.delete();
        g_tx.push_back(8'hA5); g_sl.push_back(8'hA5);
        run_txn(1'b0, 2'd0, 1, 2, 0, 1'b0, 1'b0);

        g_tx.delete(); g_sl.delete();
        g_tx.push_back(8'h3C); g_sl.push_back(8'hC3);
        run_txn(1'b0, 2'd3, 1, 1, 0, 1'b0, 1'b0);

        g_tx.delete(); g_sl.delete();
        g_tx.push_back(8'h11); g_tx.push_back(8'h22); g_tx.push_back(8'h33);
        g_sl.push_back(8'h11); g_sl.push_back(8'h22); g_sl.push_back(8'h33);
        run_txn(1'b0, 2'd1, 3, 4, 0, 1'b0, 1'b0);

        g_tx.delete(); g_sl.delete();
        g_tx.push_back(8'h01); g_sl.push_back(8'h01);
        run_txn(1'b1, 2'd0, 1, 7, 0, 1'b0, 1'b0);

        try_ignored(1'b0, 7, 1);
        try_ignored(1'b0, 6, 1);
        try_ignored(1'b0, 1, 0);

        load_words(2, 1'b0);
        run_txn(1'b0, 2'd2, 2, 5, 0, 1'b1, 1'b0);

        load_words(2, 1'b0);
        run_txn(1'b1, 2'd1, 2, 3, 0, 1'b0, 1'b1);

        load_words(2, 1'b0);
        run_txn(1'b0, 2'd0, 2, 0, 5, 1'b0, 1'b0);

        load_words(1, 1'b1);
        run_txn(1'b0, 2'd0, 1, 3, 0, 1'b0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            s   = 1'($urandom_range(0, 1));
            md  = 2'($urandom_range(0, 3));
            n   = $urandom_range(1, 4);
            ssi = s ? $urandom_range(0, 7) : $urandom_range(0, 5);
            load_words(n, 1'b0);
            run_txn(s, md, n, ssi, 0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
